// File: rtl/lane_traffic_ctrl.sv
// lane_traffic_ctrl: paced sweep that advances one car per cycle with wraparound,
// tracks a saturating speed level and latches a sticky frog/car collision flag.
module lane_traffic_ctrl #(
    parameter int NUM_CARS      = 10,
    parameter int X_WIDTH       = 6,
    parameter int MAX_X         = 20,
    parameter int SLOW_COUNT    = 700000,
    parameter int COUNTER_WIDTH = 21,
    parameter int MAX_LEVEL     = 7,
    parameter logic [NUM_CARS*X_WIDTH-1:0] CAR_SPEED  = {NUM_CARS{X_WIDTH'(1)}},
    parameter logic [NUM_CARS*X_WIDTH-1:0] CAR_INIT_X = {6'd10, 6'd9, 6'd8, 6'd7, 6'd6,
                                                         6'd5, 6'd4, 6'd3, 6'd2, 6'd1},
    parameter logic [NUM_CARS*X_WIDTH-1:0] CAR_LANE_Y = {6'd10, 6'd9, 6'd8, 6'd7, 6'd6,
                                                         6'd5, 6'd4, 6'd3, 6'd2, 6'd1},
    parameter logic [NUM_CARS-1:0]         CAR_DIR    = 10'b1010101010
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Enable,
    input  logic                          i_Level_Up,
    input  logic [X_WIDTH-1:0]            i_Frog_X,
    input  logic [X_WIDTH-1:0]            i_Frog_Y,
    input  logic                          i_Frog_Valid,
    input  logic                          i_Collision_Clr,
    output logic [NUM_CARS*X_WIDTH-1:0]   o_Car_X,
    output logic [NUM_CARS*X_WIDTH-1:0]   o_Car_Y,
    output logic [2:0]                    o_Level,
    output logic                          o_Collision,
    output logic                          o_Sweep_Done
);
    localparam int KW = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1;
    localparam int SW = X_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    state_t                        state_q, state_d;
    logic [COUNTER_WIDTH-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [NUM_CARS*X_WIDTH-1:0]   car_x_q, car_x_d;
    logic [2:0]                    level_q, level_d;
    logic                          coll_q, coll_d;
    logic                          tick, last, hit_move, hit_idle;
    logic [SW-1:0]                 cur_x, step, sum, new_x_w;
    logic [X_WIDTH-1:0]            new_x;

    assign tick = i_Enable && cnt_q == COUNTER_WIDTH'(SLOW_COUNT - 1);
    assign last = k_q == KW'(NUM_CARS - 1);

    // Step is widened one bit so X+step never overflows before the wrap test.
    always_comb begin
        cur_x    = SW'(car_x_q[k_q*X_WIDTH +: X_WIDTH]);
        step     = SW'(CAR_SPEED[k_q*X_WIDTH +: X_WIDTH]) + SW'(level_q);
        sum      = cur_x + step;
        new_x_w  = CAR_DIR[k_q] ? (cur_x >= step ? cur_x - step : cur_x + SW'(MAX_X + 1) - step)
                                : (sum <= SW'(MAX_X) ? sum : sum - SW'(MAX_X + 1));
        new_x    = new_x_w[X_WIDTH-1:0];
        hit_move = i_Frog_Valid && new_x == i_Frog_X
                   && CAR_LANE_Y[k_q*X_WIDTH +: X_WIDTH] == i_Frog_Y;
        hit_idle = 1'b0;
        for (int i = 0; i < NUM_CARS; i++)
            if (i_Frog_Valid && car_x_q[i*X_WIDTH +: X_WIDTH] == i_Frog_X
                && CAR_LANE_Y[i*X_WIDTH +: X_WIDTH] == i_Frog_Y)
                hit_idle = 1'b1;
    end

    always_comb begin
        cnt_d   = i_Enable ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = state_q == IDLE ? (tick ? MOVE : IDLE)
                : state_q == MOVE ? (last ? DONE : MOVE) : IDLE;
        k_d     = state_q == MOVE && !last ? k_q + 1'b1 : '0;
        car_x_d = car_x_q;
        if (state_q == MOVE)
            car_x_d[k_q*X_WIDTH +: X_WIDTH] = new_x;
        level_d = i_Level_Up && level_q != 3'(MAX_LEVEL) ? level_q + 1'b1 : level_q;
        coll_d  = (state_q == MOVE && hit_move) || (state_q == IDLE && hit_idle) ? 1'b1
                : i_Collision_Clr ? 1'b0 : coll_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            car_x_q <= CAR_INIT_X;
            level_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            car_x_q <= car_x_d;
            level_q <= level_d;
            coll_q  <= coll_d;
        end
    end

    assign o_Car_X      = car_x_q;
    assign o_Car_Y      = CAR_LANE_Y;
    assign o_Level      = level_q;
    assign o_Collision  = coll_q;
    assign o_Sweep_Done = state_q == DONE;
endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// tb_lane_traffic_ctrl: vector table of timed input phases with hand-computed
// expected car positions, level, collision and sweep-done, plus a mid-sweep reset sequence.
module tb_lane_traffic_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, lup, fv, clr;
    logic [5:0]  fx, fy;
    logic [23:0] car_x, car_y;
    logic [2:0]  level;
    logic        coll, sd;
    int          checks = 0;
    int          failures = 0;

    localparam logic [23:0] Y_EXP = {6'd4, 6'd3, 6'd2, 6'd1};
    localparam logic [23:0] XA    = {6'd18, 6'd3, 6'd2, 6'd1};
    localparam logic [23:0] XB    = {6'd19, 6'd6, 6'd0, 6'd2};
    localparam logic [23:0] XC    = {6'd0, 6'd9, 6'd18, 6'd3};

    lane_traffic_ctrl #(
        .NUM_CARS(4), .X_WIDTH(6), .MAX_X(19), .SLOW_COUNT(8), .COUNTER_WIDTH(4), .MAX_LEVEL(7),
        .CAR_SPEED({6'd1, 6'd3, 6'd2, 6'd1}),
        .CAR_INIT_X(XA),
        .CAR_LANE_Y(Y_EXP),
        .CAR_DIR(4'b0010)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Level_Up(lup),
        .i_Frog_X(fx), .i_Frog_Y(fy), .i_Frog_Valid(fv), .i_Collision_Clr(clr),
        .o_Car_X(car_x), .o_Car_Y(car_y), .o_Level(level),
        .o_Collision(coll), .o_Sweep_Done(sd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, en, lup, fv, fx, fy, clr, n;
        logic [23:0] x;
        int lvl, col, sd;
    } vec_t;

    vec_t v[30];

    task automatic chk(input string nm, input int idx, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", nm, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [23:0] x, input int l, input int c, input int s);
        chk("car_x", idx, car_x, x);
        chk("car_y", idx, car_y, Y_EXP);
        chk("level", idx, 24'(level), 24'(l));
        chk("collision", idx, 24'(coll), 24'(c));
        chk("sweep_done", idx, 24'(sd), 24'(s));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //        rst en lup fv fx  fy clr n   x                              lvl col sd
        v[0]  = '{1, 1, 0, 0, 0,  0, 0, 2,  XA,                            0, 0, 0};
        v[1]  = '{0, 1, 0, 0, 0,  0, 0, 7,  XA,                            0, 0, 0};
        v[2]  = '{0, 1, 0, 0, 0,  0, 0, 1,  XA,                            0, 0, 0};
        v[3]  = '{0, 1, 0, 1, 2,  1, 1, 1,  {6'd18, 6'd3, 6'd2, 6'd2},     0, 1, 0};
        v[4]  = '{0, 1, 0, 1, 2,  1, 0, 1,  {6'd18, 6'd3, 6'd0, 6'd2},     0, 1, 0};
        v[5]  = '{0, 1, 0, 0, 0,  0, 1, 1,  {6'd18, 6'd6, 6'd0, 6'd2},     0, 0, 0};
        v[6]  = '{0, 1, 0, 0, 0,  0, 0, 1,  XB,                            0, 0, 1};
        v[7]  = '{0, 1, 0, 0, 0,  0, 0, 1,  XB,                            0, 0, 0};
        v[8]  = '{0, 0, 0, 1, 19, 4, 0, 20, XB,                            0, 1, 0};
        v[9]  = '{0, 0, 0, 0, 0,  0, 1, 1,  XB,                            0, 0, 0};
        for (int i = 0; i < 8; i++)
            v[10+i] = '{0, 0, 1, 0, 0, 0, 0, 1, XB, (i < 7 ? i + 1 : 7), 0, 0};
        v[18] = '{0, 1, 0, 0, 0,  0, 0, 2,  XB,                            7, 0, 0};
        v[19] = '{0, 1, 0, 0, 0,  0, 0, 1,  XB,                            7, 0, 0};
        v[20] = '{0, 1, 0, 0, 0,  0, 0, 1,  {6'd19, 6'd6, 6'd0, 6'd10},    7, 0, 0};
        v[21] = '{0, 1, 0, 0, 0,  0, 0, 3,  {6'd7, 6'd16, 6'd11, 6'd10},   7, 0, 1};
        v[22] = '{0, 1, 0, 0, 0,  0, 0, 1,  {6'd7, 6'd16, 6'd11, 6'd10},   7, 0, 0};
        v[23] = '{1, 1, 0, 0, 0,  0, 0, 1,  XA,                            0, 0, 0};
        v[24] = '{0, 1, 0, 0, 0,  0, 0, 8,  XA,                            0, 0, 0};
        v[25] = '{0, 1, 0, 0, 0,  0, 0, 4,  XB,                            0, 0, 1};
        v[26] = '{0, 1, 0, 0, 0,  0, 0, 1,  XB,                            0, 0, 0};
        v[27] = '{0, 1, 0, 0, 0,  0, 0, 3,  XB,                            0, 0, 0};
        v[28] = '{0, 1, 0, 0, 0,  0, 0, 4,  XC,                            0, 0, 1};
        v[29] = '{0, 1, 0, 0, 0,  0, 0, 1,  XC,                            0, 0, 0};

        rst = 1'b1; en = 1'b0; lup = 1'b0; fv = 1'b0; clr = 1'b0; fx = '0; fy = '0;
        #1;
        for (int i = 0; i < 30; i++) begin
            rst = v[i].rst[0]; en = v[i].en[0]; lup = v[i].lup[0]; fv = v[i].fv[0];
            fx = 6'(v[i].fx); fy = 6'(v[i].fy); clr = v[i].clr[0];
            cyc(v[i].n);
            check_all(i, v[i].x, v[i].lvl, v[i].col, v[i].sd);
        end

        // Reset asserted between edges while car 2 is next to be updated.
        en = 1'b1; lup = 1'b0; fv = 1'b0; clr = 1'b0;
        cyc(3);
        check_all(100, XC, 0, 0, 0);
        cyc(2);
        check_all(101, {6'd0, 6'd9, 6'd16, 6'd4}, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_all(102, XA, 0, 0, 0);
        cyc(3);
        check_all(103, XA, 0, 0, 0);
        rst = 1'b0;
        cyc(8);
        check_all(104, XA, 0, 0, 0);
        cyc(1);
        check_all(105, {6'd18, 6'd3, 6'd2, 6'd2}, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
